// File: rtl/jtag_pkg.sv
// Shared definitions for the ER2 user-register hub: channel limit,
// selector width and the hub FSM state encoding.
package jtag_pkg;

    localparam int ER2_MAX_CH = 15;
    // Wide enough to index any of the ER2_MAX_CH channels.
    localparam int SEL_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_UPD   = 2'd2
    } hub_state_e;

endpackage

// File: rtl/jtag_onehot_dec.sv
// One-hot channel decoder: returns the index of the set bit and whether
// exactly one bit is set (zero or several set bits give onehot = 0).
module jtag_onehot_dec
    import jtag_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]     vec,
    output logic [SEL_W-1:0] idx,
    output logic             onehot
);

    logic [SEL_W:0] ones;

    // Population count plus index of the (last) set bit.
    always_comb begin
        ones = '0;
        idx  = '0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                ones = ones + (SEL_W+1)'(1);
                idx  = SEL_W'(i);
            end
        end
        onehot = (ones == (SEL_W+1)'(1));
    end

endmodule

// File: rtl/jtag_reg_hub.sv
// ER2 user-register hub: multiplexes one JTAG data register across NCH
// channels selected one-hot by ip_enable. Capture loads {addr, data} of
// the selected channel, shift moves it out LSB-first on jtdo2 while jtdi
// fills from the top, and Update-DR writes the shifted word back to that
// channel together with a one-cycle reg_update pulse.
// Optional build macro JTAG_HUB_LENCHK_EN: updates only apply after
// exactly DATA_W+ADDR_W shifts; a bad length sets a sticky error bit that
// is returned as an extra MSB of the next capture.
module jtag_reg_hub
    import jtag_pkg::*;
#(
    parameter int NCH    = 2,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic                  jtck,
    input  logic                  jrstn,
    input  logic                  jtdi,
    input  logic                  jshift,
    input  logic                  jupdate,
    input  logic                  jce2,
    input  logic [NCH-1:0]        ip_enable,
    input  logic                  control_datan,
    output logic                  jtdo2,
    input  logic [NCH*DATA_W-1:0] reg_d,
    input  logic [NCH*ADDR_W-1:0] reg_addr_d,
    output logic [NCH*DATA_W-1:0] reg_q,
    output logic [NCH*ADDR_W-1:0] reg_addr_q,
    output logic [NCH-1:0]        reg_update
);

    localparam int W = DATA_W + ADDR_W;
`ifdef JTAG_HUB_LENCHK_EN
    localparam int SRW = W + 1;
`else
    localparam int SRW = W;
`endif
    localparam int              CNT_W   = $clog2(W + 2);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(W + 1);

    hub_state_e            state_q, state_d;
    logic [SRW-1:0]        sr_q, sr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  armed_q, armed_d;
    logic [NCH-1:0]        cap_en_q, cap_en_d;
    logic [SEL_W-1:0]      cap_sel_q, cap_sel_d;
    logic [NCH-1:0]        upd_mask_q, upd_mask_d;
    logic [NCH*DATA_W-1:0] rdata_q, rdata_d;
    logic [NCH*ADDR_W-1:0] raddr_q, raddr_d;
`ifdef JTAG_HUB_LENCHK_EN
    logic                  err_q, err_d;
`endif

    logic [SEL_W-1:0] dec_idx;
    logic             dec_onehot;
    logic             valid;
    logic             enter_shift, do_capture, do_shift, abort, go_upd;
    logic             same_ch, len_ok, upd_ok;
    logic [W-1:0]     cap_word, upd_word;

    jtag_onehot_dec #(.N(NCH)) u_dec (
        .vec    (ip_enable),
        .idx    (dec_idx),
        .onehot (dec_onehot)
    );

    // Scan events decoded from the TAP strobes and the current state.
    always_comb begin
        valid       = dec_onehot & ~control_datan;
        enter_shift = (state_q == ST_IDLE) & jce2 & jshift & valid;
        do_capture  = (state_q == ST_IDLE) & jce2 & ~jshift & valid;
        go_upd      = (state_q == ST_IDLE) & jupdate & valid & ~enter_shift & ~do_capture;
        // Selection moving away from the captured channel kills the scan.
        abort       = (state_q == ST_SHIFT) & (~valid | (ip_enable != cap_en_q));
        // The Capture->Shift edge already carries the first data bit.
        do_shift    = enter_shift | ((state_q == ST_SHIFT) & jce2 & jshift & ~abort);
        same_ch     = (ip_enable == cap_en_q);
`ifdef JTAG_HUB_LENCHK_EN
        len_ok      = (cnt_q == CNT_W'(W));
`else
        len_ok      = 1'b1;
`endif
        upd_ok      = armed_q & same_ch & len_ok;
        cap_word    = {reg_addr_d[int'(dec_idx)*ADDR_W +: ADDR_W],
                       reg_d[int'(dec_idx)*DATA_W +: DATA_W]};
        // After a full scan the shifted-in word sits in the top W bits.
        upd_word    = sr_q[SRW-1 -: W];
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (enter_shift)  state_d = ST_SHIFT;
                else if (go_upd)  state_d = ST_UPD;
            end
            ST_SHIFT: if (!jshift || abort) state_d = ST_IDLE;
            ST_UPD:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: update pulse while in UPD, serial out only for valid scans.
    always_comb begin
        reg_update = (state_q == ST_UPD) ? upd_mask_q : '0;
        jtdo2      = valid & sr_q[0];
        reg_q      = rdata_q;
        reg_addr_q = raddr_q;
    end

    // Shift register, counter, capture bookkeeping and channel registers.
    always_comb begin
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        armed_d    = armed_q;
        cap_en_d   = cap_en_q;
        cap_sel_d  = cap_sel_q;
        upd_mask_d = '0;
        rdata_d    = rdata_q;
        raddr_d    = raddr_q;
`ifdef JTAG_HUB_LENCHK_EN
        err_d      = err_q;
`endif
        if (do_capture) begin
`ifdef JTAG_HUB_LENCHK_EN
            sr_d  = {err_q, cap_word};
            err_d = 1'b0;
`else
            sr_d  = cap_word;
`endif
            cnt_d     = '0;
            armed_d   = 1'b1;
            cap_en_d  = ip_enable;
            cap_sel_d = dec_idx;
        end else if (do_shift) begin
            sr_d  = {jtdi, sr_q[SRW-1:1]};
            cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
        end
        if (abort) armed_d = 1'b0;
        if (go_upd) begin
            // One update per capture, whatever the outcome.
            armed_d = 1'b0;
            if (upd_ok) begin
                upd_mask_d = cap_en_q;
                rdata_d[int'(cap_sel_q)*DATA_W +: DATA_W] = upd_word[DATA_W-1:0];
                raddr_d[int'(cap_sel_q)*ADDR_W +: ADDR_W] = upd_word[W-1:DATA_W];
            end
`ifdef JTAG_HUB_LENCHK_EN
            else if (armed_q && same_ch) begin
                err_d = 1'b1;
            end
`endif
        end
    end

    // State register.
    always_ff @(posedge jtck or negedge jrstn) begin
        if (!jrstn) begin
            state_q    <= ST_IDLE;
            sr_q       <= '0;
            cnt_q      <= '0;
            armed_q    <= 1'b0;
            cap_en_q   <= '0;
            cap_sel_q  <= '0;
            upd_mask_q <= '0;
            rdata_q    <= '0;
            raddr_q    <= '0;
`ifdef JTAG_HUB_LENCHK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            armed_q    <= armed_d;
            cap_en_q   <= cap_en_d;
            cap_sel_q  <= cap_sel_d;
            upd_mask_q <= upd_mask_d;
            rdata_q    <= rdata_d;
            raddr_q    <= raddr_d;
`ifdef JTAG_HUB_LENCHK_EN
            err_q      <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_jtag_reg_hub.sv
// Bench for jtag_reg_hub (NCH=2, DATA_W=8, ADDR_W=3): fixed vector table,
// hand sequences for abort / reset / length check, and random scans
// compared against a queue-based scan model.
module tb_jtag_reg_hub;

    localparam int W = 11;
`ifdef JTAG_HUB_LENCHK_EN
    localparam bit LEN = 1'b1;
`else
    localparam bit LEN = 1'b0;
`endif

    logic        jtck = 1'b0, jrstn = 1'b0, jtdi = 1'b0, jshift = 1'b0;
    logic        jupdate = 1'b0, jce2 = 1'b0, control_datan = 1'b0;
    logic [1:0]  ip_enable = 2'b00;
    logic        jtdo2;
    logic [15:0] reg_d = '0;
    logic [5:0]  reg_addr_d = '0;
    logic [15:0] reg_q;
    logic [5:0]  reg_addr_q;
    logic [1:0]  reg_update;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: per-channel registers and the sticky length error.
    logic [7:0] m_data [2];
    logic [2:0] m_addr [2];
    bit         m_err;

    jtag_reg_hub #(.NCH(2), .DATA_W(8), .ADDR_W(3)) dut (
        .jtck(jtck), .jrstn(jrstn), .jtdi(jtdi), .jshift(jshift),
        .jupdate(jupdate), .jce2(jce2), .ip_enable(ip_enable),
        .control_datan(control_datan), .jtdo2(jtdo2), .reg_d(reg_d),
        .reg_addr_d(reg_addr_d), .reg_q(reg_q), .reg_addr_q(reg_addr_q),
        .reg_update(reg_update)
    );

    always #5 jtck = ~jtck;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One jtck cycle: drive on the falling edge, settle 1 after the rising edge.
    task automatic cyc(input logic [1:0] en, input logic cdn, input logic ce2,
                       input logic sh, input logic upd, input logic tdi);
        @(negedge jtck);
        ip_enable = en; control_datan = cdn; jce2 = ce2;
        jshift = sh; jupdate = upd; jtdi = tdi;
        @(posedge jtck);
        #1;
    endtask

    // Capture, shift nbits, exit, optional update; returns observed bits/pulses.
    task automatic do_scan(input logic [1:0] en, input logic cdn, input logic [15:0] win,
                           input int nbits, input bit upd, output logic [15:0] outb,
                           output logic [1:0] upd_seen, output logic [1:0] upd_after);
        outb = '0;
        cyc(en, cdn, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) begin
            outb[i] = jtdo2;
            cyc(en, cdn, 1'b1, 1'b1, 1'b0, win[i]);
        end
        cyc(en, cdn, 1'b0, 1'b0, 1'b0, 1'b0);
        if (upd) begin
            cyc(en, cdn, 1'b0, 1'b0, 1'b1, 1'b0);
            upd_seen = reg_update;
            cyc(en, cdn, 1'b0, 1'b0, 1'b0, 1'b0);
            upd_after = reg_update;
        end else begin
            upd_seen  = reg_update;
            upd_after = reg_update;
        end
    endtask

    // Behavioural scan: the register is a bit queue; each shift pops the
    // oldest bit to TDO and appends TDI. An update takes the last W bits.
    task automatic model_scan(input logic [1:0] en, input logic cdn, input logic [15:0] win,
                              input int nbits, input bit upd, output logic [15:0] exp_out,
                              output logic [1:0] exp_upd);
        bit q[$];
        int ch;
        logic [10:0] cap, word;
        exp_out = '0;
        exp_upd = 2'b00;
        if ($countones(en) != 1 || cdn) return;
        ch  = en[1] ? 1 : 0;
        cap = {reg_addr_d[ch*3 +: 3], reg_d[ch*8 +: 8]};
        for (int j = 0; j < W; j++) q.push_back(cap[j]);
        if (LEN) begin
            q.push_back(m_err);
            m_err = 1'b0;
        end
        for (int i = 0; i < nbits; i++) begin
            exp_out[i] = q.pop_front();
            q.push_back(win[i]);
        end
        if (upd) begin
            if (!LEN || nbits == W) begin
                for (int j = 0; j < W; j++) word[j] = q[q.size() - W + j];
                m_data[ch] = word[7:0];
                m_addr[ch] = word[10:8];
                exp_upd    = en;
            end else begin
                m_err = 1'b1;
            end
        end
    endtask

    function automatic logic [15:0] exp_rq();
        return {m_data[1], m_data[0]};
    endfunction

    function automatic logic [5:0] exp_ra();
        return {m_addr[1], m_addr[0]};
    endfunction

    typedef struct {
        logic [1:0]  en;
        logic        cdn;
        logic [15:0] word;
        bit          upd;
        logic [15:0] exp_out;
        logic [1:0]  exp_upd;
        logic [15:0] exp_rq;
        logic [5:0]  exp_ra;
    } vec_t;

    vec_t tbl[7];

    initial begin
        logic [15:0] outb, eout, w;
        logic [1:0]  useen, uafter, eupd, en;
        logic        cdn;
        int          nb;
        bit          upd;

        m_data[0] = '0; m_data[1] = '0; m_addr[0] = '0; m_addr[1] = '0; m_err = 1'b0;

        // Full 11-bit scans only, so rows hold with or without length checking.
        tbl[0] = '{2'b10, 1'b0, 16'h0711, 1'b1, 16'h05A5, 2'b10, 16'h1100, 6'h38};
        tbl[1] = '{2'b01, 1'b0, 16'h023C, 1'b1, 16'h065A, 2'b01, 16'h113C, 6'h3A};
        tbl[2] = '{2'b11, 1'b0, 16'h07FF, 1'b1, 16'h0000, 2'b00, 16'h113C, 6'h3A};
        tbl[3] = '{2'b00, 1'b0, 16'h07FF, 1'b1, 16'h0000, 2'b00, 16'h113C, 6'h3A};
        tbl[4] = '{2'b01, 1'b1, 16'h07FF, 1'b1, 16'h0000, 2'b00, 16'h113C, 6'h3A};
        tbl[5] = '{2'b10, 1'b0, 16'h00FF, 1'b0, 16'h05A5, 2'b00, 16'h113C, 6'h3A};
        tbl[6] = '{2'b10, 1'b0, 16'h04C3, 1'b1, 16'h05A5, 2'b10, 16'hC33C, 6'h22};

        // Reset state while the clock runs.
        ip_enable = 2'b01;
        repeat (3) @(posedge jtck);
        #1;
        check("rst_reg_q", reg_q, 16'h0);
        check("rst_reg_addr_q", reg_addr_q, 6'h0);
        check("rst_reg_update", reg_update, 2'b00);
        check("rst_jtdo2", jtdo2, 1'b0);
        @(negedge jtck);
        jrstn = 1'b1;

        // Table vectors.
        reg_d      = {8'hA5, 8'h5A};
        reg_addr_d = {3'd5, 3'd6};
        for (int i = 0; i < 7; i++) begin
            do_scan(tbl[i].en, tbl[i].cdn, tbl[i].word, W, tbl[i].upd, outb, useen, uafter);
            check($sformatf("tbl%0d_out", i), outb & 16'h07FF, tbl[i].exp_out);
            check($sformatf("tbl%0d_upd", i), useen, tbl[i].exp_upd);
            check($sformatf("tbl%0d_upd_after", i), uafter, 2'b00);
            check($sformatf("tbl%0d_reg_q", i), reg_q, tbl[i].exp_rq);
            check($sformatf("tbl%0d_reg_addr_q", i), reg_addr_q, tbl[i].exp_ra);
        end
        m_data[0] = 8'h3C; m_data[1] = 8'hC3; m_addr[0] = 3'd2; m_addr[1] = 3'd4;

        // Selection change mid-shift aborts; a later update without capture is ignored.
        cyc(2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) cyc(2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        cyc(2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        repeat (8) cyc(2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        cyc(2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("abort_upd", reg_update, 2'b00);
        cyc(2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("abort_reg_q", reg_q, exp_rq());
        check("abort_reg_addr_q", reg_addr_q, exp_ra());

`ifdef JTAG_HUB_LENCHK_EN
        // Short scan: no update, error bit comes back once on the next capture.
        model_scan(2'b01, 1'b0, 16'h0155, 10, 1'b1, eout, eupd);
        do_scan(2'b01, 1'b0, 16'h0155, 10, 1'b1, outb, useen, uafter);
        check("len_short_upd", useen, eupd);
        check("len_short_reg_q", reg_q, exp_rq());
        model_scan(2'b10, 1'b0, 16'h0, 12, 1'b0, eout, eupd);
        do_scan(2'b10, 1'b0, 16'h0, 12, 1'b0, outb, useen, uafter);
        check("len_err_bit_set", outb[11], 1'b1);
        check("len_err_out", outb & 16'h0FFF, eout);
        model_scan(2'b10, 1'b0, 16'h0, 12, 1'b0, eout, eupd);
        do_scan(2'b10, 1'b0, 16'h0, 12, 1'b0, outb, useen, uafter);
        check("len_err_bit_clr", outb[11], 1'b0);
`endif

        // Random scans against the model.
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 5))
                0, 1:    en = 2'b01;
                2, 3:    en = 2'b10;
                4:       en = 2'b11;
                default: en = 2'b00;
            endcase
            cdn        = ($urandom_range(0, 7) == 0);
            nb         = ($urandom_range(0, 1) == 1) ? W : int'($urandom_range(0, 14));
            upd        = ($urandom_range(0, 3) != 0);
            w          = 16'($urandom);
            reg_d      = 16'($urandom);
            reg_addr_d = 6'($urandom);
            model_scan(en, cdn, w, nb, upd, eout, eupd);
            do_scan(en, cdn, w, nb, upd, outb, useen, uafter);
            check($sformatf("rnd%0d_out", it), outb & 16'((32'h1 << nb) - 1), eout);
            check($sformatf("rnd%0d_upd", it), useen, eupd);
            check($sformatf("rnd%0d_upd_after", it), uafter, 2'b00);
            check($sformatf("rnd%0d_reg_q", it), reg_q, exp_rq());
            check($sformatf("rnd%0d_reg_addr_q", it), reg_addr_q, exp_ra());
        end

        // Force known non-zero contents, then reset after 5 shift bits.
        reg_d = 16'h7E81; reg_addr_d = 6'h2B;
        model_scan(2'b01, 1'b0, 16'h0499, W, 1'b1, eout, eupd);
        do_scan(2'b01, 1'b0, 16'h0499, W, 1'b1, outb, useen, uafter);
        check("pre_rst_reg_q", reg_q, exp_rq());
        cyc(2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (5) cyc(2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        #2 jrstn = 1'b0;
        #1;
        check("arst_reg_q", reg_q, 16'h0);
        check("arst_reg_addr_q", reg_addr_q, 6'h0);
        check("arst_reg_update", reg_update, 2'b00);
        check("arst_jtdo2", jtdo2, 1'b0);
        m_data[0] = '0; m_data[1] = '0; m_addr[0] = '0; m_addr[1] = '0; m_err = 1'b0;
        repeat (2) cyc(2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge jtck);
        jrstn = 1'b1;
        cyc(2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("post_rst_upd", reg_update, 2'b00);
        cyc(2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("post_rst_reg_q", reg_q, 16'h0);
        check("post_rst_reg_addr_q", reg_addr_q, 6'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
